// File: rtl/branch_resolve_queue_pkg.sv
// Shared sizing for the branch resolve queue: global wavefront ids plus the
// issue-stage defaults for queue depth and PC width.
package branch_resolve_queue_pkg;
  localparam int WF_PER_CU    = 40;
  localparam int WF_ID_LENGTH = 6;
  localparam int BRQ_DEPTH    = 4;
  localparam int PC_LENGTH    = 32;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// SALU -> queue -> fetch branch bus. master drives SALU results and fetch
// ready; slave is the queue itself.
interface branch_resolve_queue_if
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PC_W  = PC_LENGTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    salu_branch_valid;
  logic [WF_ID_LENGTH-1:0] salu_branch_wfid;
  logic                    salu_branch_taken;
  logic [PC_W-1:0]         salu_branch_target;
  logic                    fetch_branch_ready;
  logic                    f_salu_branch_en;
  logic [WF_ID_LENGTH-1:0] f_salu_branch_wfid;
  logic                    f_salu_branch_taken;
  logic [PC_W-1:0]         f_salu_branch_pc;
  logic                    brq_valid;
  logic [CNT_W-1:0]        brq_count;
  logic                    brq_overflow_err;
  logic                    brq_dup_err;

  modport master (
    output salu_branch_valid, salu_branch_wfid, salu_branch_taken, salu_branch_target,
    output fetch_branch_ready,
    input  f_salu_branch_en, f_salu_branch_wfid, f_salu_branch_taken, f_salu_branch_pc,
    input  brq_valid, brq_count, brq_overflow_err, brq_dup_err
  );

  modport slave (
    input  salu_branch_valid, salu_branch_wfid, salu_branch_taken, salu_branch_target,
    input  fetch_branch_ready,
    output f_salu_branch_en, f_salu_branch_wfid, f_salu_branch_taken, f_salu_branch_pc,
    output brq_valid, brq_count, brq_overflow_err, brq_dup_err
  );
endinterface

// File: rtl/branch_resolve_queue_entry_mem.sv
// DEPTH x {wfid, taken, pc} register file: one write port, one async read
// port, and per-entry valid/wfid taps for the duplicate compare.
module brq_entry_mem
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PC_W  = PC_LENGTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [AW-1:0]                       waddr,
  input  logic [WF_ID_LENGTH-1:0]             wr_wfid,
  input  logic                                wr_taken,
  input  logic [PC_W-1:0]                     wr_pc,
  input  logic                                clr,
  input  logic [AW-1:0]                       caddr,
  input  logic [AW-1:0]                       raddr,
  output logic [WF_ID_LENGTH-1:0]             rd_wfid,
  output logic                                rd_taken,
  output logic [PC_W-1:0]                     rd_pc,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][WF_ID_LENGTH-1:0]  ent_wfid
);
  logic [DEPTH-1:0][WF_ID_LENGTH-1:0] wfid_q;
  logic [DEPTH-1:0]                   taken_q;
  logic [DEPTH-1:0][PC_W-1:0]         pc_q;
  logic [DEPTH-1:0]                   vld_q;

  // Write follows clear so a full-queue push+pop (same slot) leaves it valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wfid_q  <= '0;
      taken_q <= '0;
      pc_q    <= '0;
      vld_q   <= '0;
    end else begin
      if (clr) vld_q[caddr] <= 1'b0;
      if (we) begin
        wfid_q[waddr]  <= wr_wfid;
        taken_q[waddr] <= wr_taken;
        pc_q[waddr]    <= wr_pc;
        vld_q[waddr]   <= 1'b1;
      end
    end
  end

  assign rd_wfid  = wfid_q[raddr];
  assign rd_taken = taken_q[raddr];
  assign rd_pc    = pc_q[raddr];
  assign ent_vld  = vld_q;
  assign ent_wfid = wfid_q;
endmodule

// File: rtl/branch_resolve_queue.sv
// Circular FIFO of resolved SALU branches feeding fetch; flags dropped pushes
// and wavefronts that already have a branch queued.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PC_W  = PC_LENGTH
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]                      rd_ptr, wr_ptr;
  logic [CW-1:0]                      count;
  logic                               ovf_err, dup_err;
  logic                               full, vld, push, pop, dup_hit;
  logic [DEPTH-1:0]                   ent_vld;
  logic [DEPTH-1:0][WF_ID_LENGTH-1:0] ent_wfid;

  assign vld  = (count != '0);
  assign full = (count == CW'(DEPTH));
  assign pop  = vld & bus.fetch_branch_ready;
  assign push = bus.salu_branch_valid & (~full | pop);

  // The entry leaving this cycle may legitimately share the incoming wfid.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i] && ent_wfid[i] == bus.salu_branch_wfid && !(pop && AW'(i) == rd_ptr))
        dup_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      dup_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.salu_branch_valid && full && !pop) ovf_err <= 1'b1;
      if (push && dup_hit)                       dup_err <= 1'b1;
    end
  end

  brq_entry_mem #(.DEPTH(DEPTH), .PC_W(PC_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .we       (push),
    .waddr    (wr_ptr),
    .wr_wfid  (bus.salu_branch_wfid),
    .wr_taken (bus.salu_branch_taken),
    .wr_pc    (bus.salu_branch_target),
    .clr      (pop),
    .caddr    (rd_ptr),
    .raddr    (rd_ptr),
    .rd_wfid  (bus.f_salu_branch_wfid),
    .rd_taken (bus.f_salu_branch_taken),
    .rd_pc    (bus.f_salu_branch_pc),
    .ent_vld  (ent_vld),
    .ent_wfid (ent_wfid)
  );

  assign bus.brq_valid        = vld;
  assign bus.f_salu_branch_en = pop;
  assign bus.brq_count        = count;
  assign bus.brq_overflow_err = ovf_err;
  assign bus.brq_dup_err      = dup_err;
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Buffers branch outcomes produced by the SALU and delivers them, one per cycle, to fetch under a ready handshake. Sits directly upstream of the pending-branch tracker. The accepted-delivery strobe `f_salu_branch_en`/`f_salu_branch_wfid` is the signal that tracker uses to clear a wavefront's pending branch. Fetch uses the taken flag and target PC to redirect the wavefront.

## Interface
Parameters:
- `DEPTH`, 4: queue entries, power of two, 2..16.
- `PC_W`, 32: branch target width.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-low reset.
- `salu_branch_valid` in 1: SALU has resolved a branch this cycle.
- `salu_branch_wfid` in `WF_ID_LENGTH`: wavefront of the resolved branch.
- `salu_branch_taken` in 1: branch outcome.
- `salu_branch_target` in `PC_W`: next PC for the wavefront (target if taken, fall-through if not).
- `fetch_branch_ready` in 1: fetch accepts the head entry this cycle.
- `f_salu_branch_en` out 1: head entry accepted this cycle; pulse, one per entry.
- `f_salu_branch_wfid` out `WF_ID_LENGTH`: head wavefront id.
- `f_salu_branch_taken` out 1: head outcome.
- `f_salu_branch_pc` out `PC_W`: head next PC.
- `brq_valid` out 1: head entry valid.
- `brq_count` out clog2(`DEPTH`+1): occupancy.
- `brq_overflow_err` out 1: sticky; a push was dropped.
- `brq_dup_err` out 1: sticky; a pushed wfid was already queued.

## Operation
- Circular FIFO with `rd_ptr`, `wr_ptr` and `count` registers.
- **Push:** occurs when `salu_branch_valid` = 1 and the queue is not full, or it is full and a pop occurs in the same cycle. The entry is written at `wr_ptr`; `wr_ptr` wraps modulo `DEPTH`.
- **Pop:** occurs when `brq_valid` & `fetch_branch_ready`, and `rd_ptr` advances.
- `f_salu_branch_en` = `brq_valid` & `fetch_branch_ready`. This is the only combinational path from an input to an output.
- The head fields (`f_salu_branch_wfid`/`taken`/`pc`) are driven from the storage entry at `rd_ptr`. They are don't-care when `brq_valid` = 0 but must not be X in simulation, so storage is reset to 0.
- **Count update:** push only gives +1; pop only gives −1; push and pop together leave it unchanged.
- **Full with no pop:** a push is dropped, storage and pointers are unchanged, and `brq_overflow_err` is set until reset.
- **Duplicate check:** the pushed wfid is compared against every valid entry. A pop of the same wfid in the same cycle is excluded from the check. On a match, `brq_dup_err` is set until reset and the entry is still enqueued. A wavefront has at most one branch in flight, so a match indicates an upstream bug.
- `fetch_branch_ready` is ignored while the queue is empty.

## Timing
- Reset, sampled on a rising `clk` edge with `rst` = 0:
  - `count`, pointers, storage and both error flags clear to 0.
  - All outputs read 0 in the following cycle.
  - Any push or pop in the reset cycle is discarded, including mid-stream.
- **Latency:** a push in cycle N gives `brq_valid` = 1 with that entry at the head in cycle N+1. There is no same-cycle bypass; the earliest `f_salu_branch_en` is in cycle N+1.
- **Throughput:** one push and one pop per cycle sustained, with no bubbles at any occupancy.
- **Handshake:** fetch may hold `fetch_branch_ready` low indefinitely. The head is stable while it is not accepted.
- **Wrap-around:** pointers wrap from `DEPTH`−1 to 0 with no lost or repeated entry.
- **Full:** `brq_count` = `DEPTH`. Simultaneous push+pop when full is legal and loses nothing.
- **Empty:** simultaneous push+pop is impossible, because the pop needs `brq_valid`.

## Structure
- `WF_ID_LENGTH` and `WF_PER_CU` come from the shared global definitions.
- Add `BRQ_DEPTH` (default 4) and `PC_LENGTH` (32) to the issue definitions; this block's parameters take them as defaults.
- One sub-module: `brq_entry_mem`, a `DEPTH` × (`WF_ID_LENGTH`+1+`PC_W`) register file. It has one write port and one asynchronous read port, plus the per-entry wfid/valid vectors that feed the duplicate compare.
- Pointer, count and flag logic stays in the top module.

## Test plan
- **Single branch:** after reset, push wfid 5, taken, pc 0x100 at cycle 10 with ready held high. Required: `f_salu_branch_en` = 1 with wfid 5, taken 1, pc 0x100 at cycle 11, and `brq_count` back to 0 at cycle 12.
- **Backpressure and order:** push wfids 1, 2, 3, 4 on consecutive cycles with ready low. Required: count 4 and `brq_valid` = 1. Then raise ready; required: four consecutive `en` pulses carrying 1, 2, 3, 4, then `brq_valid` = 0.
- **Overflow:** DEPTH=4 queue full, ready low, push wfid 9. Required: count stays 4, `brq_overflow_err` = 1 and stays set, and wfid 9 never appears. Repeat with ready high: no error, and wfid 9 is delivered last.
- **Wrap:** 20 cycles of continuous push+pop with ready high. Required: outputs follow the inputs exactly one cycle later, count stays at 1, and pointers wrap 5 times.
- **Duplicate:** push wfid 7 twice while the first copy is still queued. Required: `brq_dup_err` = 1. Then push wfid 7 in the same cycle the queued wfid-7 entry pops; required: no error.
- **Reset mid-stream:** count 3, drive `rst` = 0 for one cycle alongside a push. Required: next cycle count 0, `brq_valid` 0, `en` 0, both error flags 0, and the pushed entry is not delivered.
